// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace UART: line FSM states,
// trace entry layout and ASCII helpers.
package debug_trace_pkg;

    localparam int unsigned LINE_BYTES = 7;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        NEXT = 2'd3
    } lineState_e;

    typedef struct packed {
        logic [11:0] pc;
        logic [3:0]  acc;
    } traceEntry_t;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        hexAscii = (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter; start=0, LSB first, stop=1, CLK_DIV clocks per bit.
// done pulses during the last clock of the stop bit.
module uart_tx_byte #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);

    localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);
    localparam logic [3:0]       STOP_IDX = 4'd9;

    logic [CNT_W-1:0] baudCnt;
    logic [3:0]       bitIdx;
    logic [9:0]       frame;

    // Frame shifts right; tx always holds the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx      <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b0;
            baudCnt <= '0;
            bitIdx  <= '0;
            frame   <= '1;
        end else begin
            done <= busy && (bitIdx == STOP_IDX) && (baudCnt == CNT_PRE);
            if (!busy) begin
                if (start) begin
                    frame   <= {1'b1, data, 1'b0};
                    tx      <= 1'b0;
                    busy    <= 1'b1;
                    baudCnt <= '0;
                    bitIdx  <= '0;
                end
            end else if (baudCnt == CNT_LAST) begin
                baudCnt <= '0;
                if (bitIdx == STOP_IDX) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    bitIdx <= bitIdx + 4'd1;
                    tx     <= frame[1];
                    frame  <= {1'b1, frame[9:1]};
                end
            end else begin
                baudCnt <= baudCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_trace_uart.sv
// Captures {PC, ACC} on commit into a FIFO and prints each entry as "PPP:A\r\n"
// over UART. Optional macro DEBUG_TRACE_STALL_EN adds the stallReq output.
module debug_trace_uart
    import debug_trace_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        traceEn,
    input  logic                        commitStrobe,
    input  logic [11:0]                 pcAddr,
    input  logic [3:0]                  accIn,
    output logic                        uartTx,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount,
    output logic [7:0]                  overflowCnt,
    output logic                        busy
`ifdef DEBUG_TRACE_STALL_EN
    ,
    output logic                        stallReq
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  LAST_BYTE = 3'(LINE_BYTES - 1);

    traceEntry_t      fifoMem [FIFO_DEPTH];
    traceEntry_t      lineReg;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] countNext;
    logic             push;
    logic             full;
    logic             accept;
    logic             drop;
    logic             pop;

    lineState_e state;
    lineState_e stateNext;
    logic [2:0] byteIdx;
    logic       byteInc;
    logic       txStart;
    logic [7:0] txData;
    logic       txDone;
    logic       txBusy;

    // A pop in the same cycle frees a slot for the incoming capture.
    always_comb begin
        push      = commitStrobe & traceEn;
        full      = (fifoCount == CNT_W'(FIFO_DEPTH));
        accept    = push & (~full | pop);
        drop      = push & ~accept;
        countNext = fifoCount + CNT_W'(accept) - CNT_W'(pop);
    end

    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        txStart   = 1'b0;
        byteInc   = 1'b0;
        case (state)
            IDLE: begin
                if (fifoCount != '0) begin
                    pop       = 1'b1;
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                if (!txBusy) begin
                    txStart   = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (txDone) begin
                    stateNext = NEXT;
                end
            end
            NEXT: begin
                if (byteIdx == LAST_BYTE) begin
                    stateNext = IDLE;
                end else begin
                    byteInc   = 1'b1;
                    stateNext = LOAD;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wrPtr       <= '0;
            rdPtr       <= '0;
            fifoCount   <= '0;
            overflowCnt <= '0;
            busy        <= 1'b0;
            byteIdx     <= '0;
            lineReg     <= '0;
        end else begin
            state     <= stateNext;
            fifoCount <= countNext;
            busy      <= (countNext != '0) | (stateNext != IDLE);
            if (accept) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr   <= rdPtr + PTR_W'(1);
                lineReg <= fifoMem[rdPtr];
                byteIdx <= '0;
            end else if (byteInc) begin
                byteIdx <= byteIdx + 3'd1;
            end
            if (drop && (overflowCnt != 8'hFF)) begin
                overflowCnt <= overflowCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifoMem[wrPtr] <= '{pc: pcAddr, acc: accIn};
        end
    end

`ifdef DEBUG_TRACE_STALL_EN
    // Raised one slot early so the CPU halts before an entry can be lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallReq <= 1'b0;
        end else begin
            stallReq <= traceEn & (fifoCount >= CNT_W'(FIFO_DEPTH - 1));
        end
    end
`endif

    always_comb begin
        txData = ASCII_LF;
        case (byteIdx)
            3'd0:    txData = hexAscii(lineReg.pc[11:8]);
            3'd1:    txData = hexAscii(lineReg.pc[7:4]);
            3'd2:    txData = hexAscii(lineReg.pc[3:0]);
            3'd3:    txData = ASCII_COLON;
            3'd4:    txData = hexAscii(lineReg.acc);
            3'd5:    txData = ASCII_CR;
            default: txData = ASCII_LF;
        endcase
    end

    uart_tx_byte #(
        .CLK_DIV(CLK_DIV)
    ) uTx (
        .clk  (clk),
        .rst  (rst),
        .start(txStart),
        .data (txData),
        .tx   (uartTx),
        .done (txDone),
        .busy (txBusy)
    );

endmodule

// File: tb/tb_debug_trace_uart.sv
// Self-checking bench for debug_trace_uart: queue-based reference model plus a UART receiver.
module tb_debug_trace_uart;

    localparam int D     = 4;
    localparam int DEPTH = 4;
    // Pop cycle to next IDLE cycle: IDLE, 7 frames, 6 NEXT/LOAD gaps, final NEXT, first LOAD.
    localparam int LINE_CYC = 3 + 6 * (10 * D + 2) + 10 * D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        traceEn = 1'b0;
    logic        commitStrobe = 1'b0;
    logic [11:0] pcAddr = '0;
    logic [3:0]  accIn = '0;
    logic        uartTx;
    logic [$clog2(DEPTH):0] fifoCount;
    logic [7:0]  overflowCnt;
    logic        busy;
`ifdef DEBUG_TRACE_STALL_EN
    logic        stallReq;
`endif

    debug_trace_uart #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .traceEn(traceEn), .commitStrobe(commitStrobe),
        .pcAddr(pcAddr), .accIn(accIn), .uartTx(uartTx), .fifoCount(fifoCount),
        .overflowCnt(overflowCnt), .busy(busy)
`ifdef DEBUG_TRACE_STALL_EN
        , .stallReq(stallReq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] modelQ[$];
    logic [15:0] expLines[$];
    int freeAt = 0;
    int lastPop = 0;
    int ovfExp = 0;

    // Receiver output
    logic [7:0] rxQ[$];
    int rxT[$];
    int rxFrameErr = 0;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return 8'h41 + 8'(n) - 8'd10;
    endfunction

    function automatic logic [7:0] expByte(input logic [15:0] e, input int k);
        case (k)
            0: return hexChar(e[15:12]);
            1: return hexChar(e[11:8]);
            2: return hexChar(e[7:4]);
            3: return 8'h3A;
            4: return hexChar(e[3:0]);
            5: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // UART receiver sampling each bit near its middle.
    initial begin
        int t0;
        logic [7:0] b;
        logic sb;
        forever begin
            @(negedge clk);
            if (uartTx === 1'b0) begin
                t0 = cyc;
                repeat (D / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (D) @(negedge clk);
                    b[i] = uartTx;
                end
                repeat (D) @(negedge clk);
                sb = uartTx;
                rxQ.push_back(b);
                rxT.push_back(t0);
                if (sb !== 1'b1) rxFrameErr++;
            end
        end
    end

    // Drive one cycle of stimulus and advance the model across the coming edge.
    task automatic step(input logic s, input logic en, input logic r,
                        input logic [11:0] pc, input logic [3:0] acc);
        rst = r; commitStrobe = s; traceEn = en; pcAddr = pc; accIn = acc;
        if (r) begin
            modelQ.delete();
            ovfExp = 0;
            freeAt = 0;
        end else begin
            if (cyc >= freeAt && modelQ.size() > 0) begin
                expLines.push_back(modelQ.pop_front());
                freeAt = cyc + LINE_CYC;
                lastPop = cyc;
            end
            if (s && en) begin
                if (modelQ.size() < DEPTH) modelQ.push_back({pc, acc});
                else if (ovfExp < 255) ovfExp++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic en);
        step(1'b0, en, 1'b0, 12'($urandom), 4'($urandom));
    endtask

    task automatic drain(input logic en);
        while (modelQ.size() > 0 || cyc < freeAt + 2) idle(en);
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b1, 12'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 12'h0, 4'h0);
        checks++; if (uartTx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uartTx); end
        checks++; if (fifoCount !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifoCount); end
        checks++; if (overflowCnt !== 8'h00) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflowCnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_single_line;
        logic [7:0] golden [7];
        int c0;
        golden = '{8'h31, 8'h32, 8'h41, 8'h3A, 8'h35, 8'h0D, 8'h0A};
        c0 = cyc;
        step(1'b1, 1'b1, 1'b0, 12'h12A, 4'h5);
        checks++; if (fifoCount !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifoCount); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        drain(1'b1);
        checks++;
        if (rxQ.size() != 7) begin
            failures++; $display("FAIL single_nbytes got=%0d exp=7", rxQ.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rxQ[i] !== golden[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, rxQ[i], golden[i]); end
            end
            checks++; if (rxT[0] - c0 != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", rxT[0] - c0); end
            checks++; if (rxT[6] + 10 * D - rxT[0] != 7 * 40 + 12) begin
                failures++; $display("FAIL single_linelen got=%0d exp=%0d", rxT[6] + 10 * D - rxT[0], 7 * 40 + 12); end
        end
        checks++; if (rxFrameErr != 0) begin failures++; $display("FAIL single_framing got=%0d exp=0", rxFrameErr); end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_overflow_and_coincide;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        checks++; if (overflowCnt !== 8'd1 || ovfExp != 1) begin failures++; $display("FAIL ovf_count got=%0d exp=1 model=%0d", overflowCnt, ovfExp); end
        checks++; if (fifoCount !== DEPTH) begin failures++; $display("FAIL ovf_fill got=%0d exp=%0d", fifoCount, DEPTH); end
        while (cyc < freeAt) idle(1'b1);
        checks++; if (fifoCount !== DEPTH) begin failures++; $display("FAIL coincide_pre got=%0d exp=%0d", fifoCount, DEPTH); end
        step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        checks++; if (fifoCount !== DEPTH) begin failures++; $display("FAIL coincide_count got=%0d exp=%0d", fifoCount, DEPTH); end
        checks++; if (overflowCnt !== 8'd1) begin failures++; $display("FAIL coincide_ovf got=%0d exp=1", overflowCnt); end
        drain(1'b1);
        checks++;
        if (rxQ.size() != 7 * 6 || expLines.size() != 6) begin
            failures++; $display("FAIL ovf_nbytes got=%0d exp=%0d", rxQ.size(), 42);
        end else begin
            for (int i = 0; i < rxQ.size(); i++) begin
                checks++;
                if (rxQ[i] !== expByte(expLines[i / 7], i % 7)) begin
                    failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, rxQ[i], expByte(expLines[i / 7], i % 7)); end
            end
        end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_trace_en;
        for (int i = 0; i < 50; i++) begin
            step(1'($urandom), 1'b0, 1'b0, 12'($urandom), 4'($urandom));
            checks++; if (fifoCount !== 0) begin failures++; $display("FAIL en_off_count cyc=%0d got=%0d exp=0", cyc, fifoCount); end
            checks++; if (uartTx !== 1'b1) begin failures++; $display("FAIL en_off_tx cyc=%0d got=%b exp=1", cyc, uartTx); end
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        for (int i = 0; i < 20; i++) step(1'($urandom), 1'b0, 1'b0, 12'($urandom), 4'($urandom));
        drain(1'b0);
        checks++;
        if (rxQ.size() != 21 || expLines.size() != 3) begin
            failures++; $display("FAIL en_drain_nbytes got=%0d exp=21", rxQ.size());
        end else begin
            for (int i = 0; i < 21; i++) begin
                checks++;
                if (rxQ[i] !== expByte(expLines[i / 7], i % 7)) begin
                    failures++; $display("FAIL en_byte%0d got=%h exp=%h", i, rxQ[i], expByte(expLines[i / 7], i % 7)); end
            end
        end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_reset_mid_frame;
        int target;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        target = lastPop + 2 + 3 * (10 * D + 2) + 2 * D;
        while (cyc < target) idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 12'h0, 4'h0);
        checks++; if (uartTx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", uartTx); end
        checks++; if (fifoCount !== 0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", fifoCount); end
        checks++; if (overflowCnt !== 8'd0) begin failures++; $display("FAIL midrst_ovf got=%0d exp=0", overflowCnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (60) idle(1'b1);
        rxQ.delete(); rxT.delete(); expLines.delete(); rxFrameErr = 0;
        step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        drain(1'b1);
        checks++;
        if (rxQ.size() != 7 || expLines.size() != 1) begin
            failures++; $display("FAIL midrst_nbytes got=%0d exp=7", rxQ.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rxQ[i] !== expByte(expLines[0], i)) begin
                    failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, rxQ[i], expByte(expLines[0], i)); end
            end
        end
        checks++; if (rxFrameErr != 0) begin failures++; $display("FAIL midrst_framing got=%0d exp=0", rxFrameErr); end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_random;
        logic s, en;
        for (int i = 0; i < 2000; i++) begin
            s  = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 9) != 0);
            step(s, en, 1'b0, 12'($urandom), 4'($urandom));
            checks++; if (fifoCount !== modelQ.size()) begin
                failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, fifoCount, modelQ.size()); end
            checks++; if (busy !== (modelQ.size() > 0 || cyc < freeAt)) begin
                failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, (modelQ.size() > 0 || cyc < freeAt)); end
        end
        checks++; if (overflowCnt !== 8'(ovfExp)) begin failures++; $display("FAIL rand_ovf got=%0d exp=%0d", overflowCnt, ovfExp); end
        drain(1'b1);
        checks++;
        if (rxQ.size() != 7 * expLines.size()) begin
            failures++; $display("FAIL rand_nbytes got=%0d exp=%0d", rxQ.size(), 7 * expLines.size());
        end else begin
            for (int i = 0; i < rxQ.size(); i++) begin
                checks++;
                if (rxQ[i] !== expByte(expLines[i / 7], i % 7)) begin
                    failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, rxQ[i], expByte(expLines[i / 7], i % 7)); end
            end
        end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 400; i++) step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        checks++; if (overflowCnt !== 8'hFF) begin failures++; $display("FAIL sat_ovf got=%0d exp=255", overflowCnt); end
        checks++; if (ovfExp != 255) begin failures++; $display("FAIL sat_model got=%0d exp=255", ovfExp); end
        drain(1'b1);
        checks++; if (overflowCnt !== 8'hFF) begin failures++; $display("FAIL sat_hold got=%0d exp=255", overflowCnt); end
        checks++;
        if (rxQ.size() != 7 * expLines.size()) begin
            failures++; $display("FAIL sat_nbytes got=%0d exp=%0d", rxQ.size(), 7 * expLines.size());
        end else begin
            for (int i = 0; i < rxQ.size(); i++) begin
                checks++;
                if (rxQ[i] !== expByte(expLines[i / 7], i % 7)) begin
                    failures++; $display("FAIL sat_byte%0d got=%h exp=%h", i, rxQ[i], expByte(expLines[i / 7], i % 7)); end
            end
        end
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask

`ifdef DEBUG_TRACE_STALL_EN
    task automatic test_stall;
        step(1'b0, 1'b1, 1'b1, 12'h0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        checks++; if (fifoCount !== DEPTH - 1) begin failures++; $display("FAIL stall_fill got=%0d exp=%0d", fifoCount, DEPTH - 1); end
        checks++; if (stallReq !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", stallReq); end
        idle(1'b1);
        checks++; if (stallReq !== 1'b1) begin failures++; $display("FAIL stall_rise got=%b exp=1", stallReq); end
        for (int i = 0; i < 300; i++) step(~stallReq, 1'b1, 1'b0, 12'($urandom), 4'($urandom));
        checks++; if (overflowCnt !== 8'd0) begin failures++; $display("FAIL stall_nodrop got=%0d exp=0", overflowCnt); end
        drain(1'b1);
        rxQ.delete(); rxT.delete(); expLines.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_overflow_and_coincide();
        test_trace_en();
        test_reset_mid_frame();
        test_random();
        test_saturation();
`ifdef DEBUG_TRACE_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_trace_uart.md
Name: debug_trace_uart

Overview:
- Downstream consumer of the CPU top's debug outputs (pcAddr, accDebug).
- On every instruction-commit strobe it captures the {PC, ACC} pair into a small FIFO.
- It serialises each captured entry as an ASCII line over a UART 8N1 transmitter, giving a board-level execution trace without a logic analyser.
- It sits beside the CPU top in the board top, on the same clock.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit (minimum 2).
- FIFO_DEPTH, 8, trace entries buffered (power of two, ≥2).

Ports:
- clk  input  1  system clock, same clock that drives the CPU.
- rst  input  1  synchronous, active-high reset.
- traceEn  input  1  capture enable; entries are captured only while high.
- commitStrobe  input  1  one-cycle pulse at instruction commit (CPU commitPulse).
- pcAddr  input  12  PC value to capture.
- accIn  input  4  ACC value to capture.
- uartTx  output  1  serial line, idle high.
- fifoCount  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflowCnt  output  8  saturating count of dropped entries.
- busy  output  1  high when the FIFO is non-empty or a line is being transmitted.

Behaviour:
- Clocking and reset
  - Single clock. rst is synchronous and active-high, sampled on the clk rising edge.
  - Reset values: uartTx=1, fifoCount=0, overflowCnt=0, busy=0, FIFO pointers=0, FSM=IDLE, baud counter=0.
  - Reset mid-frame aborts immediately. uartTx returns to 1 on the cycle after the reset edge. Partial bytes are not completed.
- Capture
  - An entry is captured when commitStrobe & traceEn are both high on a clk edge.
  - Entry = {pcAddr, accIn} (16 bits), written at the write pointer.
- FIFO full
  - If a capture arrives while the FIFO is full, the entry is dropped and overflowCnt increments, saturating at 8'hFF.
- Simultaneous events
  - A capture and a pop in the same cycle when full: the pop happens first, so the capture succeeds and fifoCount is unchanged.
  - When empty, no pop occurs and the capture succeeds.
- Pointers wrap modulo FIFO_DEPTH.
- Line format, 7 bytes, uppercase ASCII hex:
  - PC[11:8], PC[7:4], PC[3:0], ':', ACC, 0x0D, 0x0A.
  - Hex mapping: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
- Line FSM
  - States: IDLE, LOAD, SEND, NEXT.
  - IDLE: when the FIFO is non-empty, pop the head into the line register, set byteIdx=0, go to LOAD.
  - LOAD: select byte[byteIdx] and start the transmitter, go to SEND.
  - SEND: wait for the transmitter to report done, go to NEXT.
  - NEXT: if byteIdx==6, go to IDLE; else byteIdx+1 and go to LOAD.
  - The pop happens on the IDLE→LOAD transition. The entry leaves the FIFO when its line starts, not when it ends.
- Byte transmitter
  - Frame is 10 bits: start=0, data LSB first, stop=1. Each bit lasts exactly CLK_DIV clocks.
  - The baud counter restarts at every frame start.
  - A done pulse is asserted in the last clock of the stop bit.
  - Back-to-back bytes within a line are separated by exactly 2 extra idle-high clocks (the NEXT and LOAD states).
- busy = (fifoCount≠0) | (FSM≠IDLE).
- Capture latency: a capture on cycle N gives fifoCount incremented at N+1. The start bit appears at N+3 at the earliest (FIFO write, IDLE pop, LOAD).
- traceEn going low does not flush the FIFO; buffered entries still drain.

Optional Feature:
- Macro: DEBUG_TRACE_STALL_EN
- With the macro defined:
  - An extra output `stallReq` (1 bit) is added.
  - stallReq = (fifoCount ≥ FIFO_DEPTH-1) & traceEn, registered, reset 0.
  - The board top ANDs it into the CPU clock enable so no entries are lost.
  - overflowCnt still counts any drop.
- Without the macro: the port is absent and entries are dropped when full.

Decomposition:
- Shared package `debug_trace_pkg` holds:
  - ASCII constants ASCII_COLON=8'h3A, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - A hex-nibble-to-ASCII function.
  - The line FSM state enum.
  - LINE_BYTES=7.
- One sub-module is natural: `uart_tx_byte`.
  - Inputs: clk, rst, start, data[7:0].
  - Outputs: tx, done, busy.
  - Parameterised by CLK_DIV.
  - Reusable by later UART blocks.

Test Plan:
- Reset, then single strobe with pcAddr=12'h12A, accIn=4'h5, CLK_DIV=4 → uartTx decodes to 0x31,0x32,0x41,0x3A,0x35,0x0D,0x0A. Each bit is 4 clocks, and the line totals 7×40+12 clocks.
- FIFO_DEPTH=4 with 6 strobes on consecutive cycles while transmitting is stalled by the first line → 1 entry popped, then 4 buffered, 1 dropped. overflowCnt=1 and exactly 5 lines are emitted in capture order.
- Full FIFO with a strobe coinciding with the IDLE pop → entry accepted, overflowCnt unchanged, fifoCount unchanged.
- traceEn=0 while strobes toggle → fifoCount stays 0 and uartTx stays 1. Deasserting traceEn with 3 entries buffered → all 3 lines are still sent.
- rst asserted in the middle of byte 3 → next cycle uartTx=1, fifoCount=0, overflowCnt=0, busy=0. A new strobe afterwards produces a complete fresh line.
- 300 drops → overflowCnt saturates at 0xFF. With DEBUG_TRACE_STALL_EN, stallReq rises the cycle after fifoCount reaches FIFO_DEPTH-1 and no drops occur.
